// File: rtl/averaged_bcd_converter.sv
// Periodic binary-to-BCD converter feeding the seven-segment display driver.
// Latency: N+1 cycles from the capture tick to the valid pulse (17 at N=16).
// Backpressure: none. The display driver must accept valid whenever it pulses.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high
//   EN        enables the update timer; an in-flight conversion always completes
//   Din       averaged sample, sampled only on the capture tick
//   bcd       packed BCD, digit 0 (units) in bits [3:0], held between updates
//   valid     one-cycle strobe coincident with the first cycle of a new bcd
//   busy      high while a conversion is in progress
//   overflow  last captured value exceeded 10^DIGITS-1 (bcd saturated to all 9s)
//
// Optional feature: define BCD_LEADING_ZERO_BLANK_EN to replace leading zero
// digits (MSD down to digit 1) with 4'hF, which the display driver shows blank.

module averaged_bcd_converter #(
    parameter int N             = 16,
    parameter int DIGITS        = 5,
    parameter int UPDATE_PERIOD = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EN,
    input  logic [N-1:0]          Din,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;             // BCD field width
    localparam int SW = N + BW;                 // full shift register width
    localparam int TW = $clog2(UPDATE_PERIOD);  // update timer width
    localparam int IW = $clog2(N + 1);          // iteration counter width
    // 10^DIGITS < 16^DIGITS, so max(N, BW) bits holds both operands exactly.
    localparam int CW = (N > BW) ? N : BW;

    // A new tick must never arrive before the previous conversion finished.
    if (UPDATE_PERIOD < N + 3) begin : g_period_check
        $error("averaged_bcd_converter: UPDATE_PERIOD must be >= N+3");
    end

    function automatic logic [CW-1:0] pow10(input int d);
        logic [CW-1:0] p;
        p = CW'(1);
        for (int i = 0; i < d; i++) begin
            p = p * CW'(10);
        end
        return p;
    endfunction

    localparam logic [CW-1:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;

    logic            tick;
    logic [SW-1:0]   sr_adj;
    logic [BW-1:0]   digits_fmt;

    // Update timer: holds while EN is low, wraps to 0 on the tick edge.
    assign tick = EN && (timer_q == TW'(UPDATE_PERIOD - 1));

    always_comb begin
        timer_d = timer_q;
        if (EN) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
        end
    end

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift,
    // so that the shift carries into the next decade correctly.
    always_comb begin
        sr_adj = sr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_q[N + 4*d +: 4] >= 4'd5) begin
                sr_adj[N + 4*d +: 4] = sr_q[N + 4*d +: 4] + 4'd3;
            end
        end
    end

    // Final digit formatting applied when the result is loaded.
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        digits_fmt = sr_q[SW-1:N];
        lead       = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (digits_fmt[4*d +: 4] == 4'h0)) begin
                digits_fmt[4*d +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        digits_fmt = sr_q[SW-1:N];
    end
`endif

    // FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ticks outside IDLE are dropped by construction.
                if (tick) begin
                    sr_d       = {{BW{1'b0}}, Din};
                    ovf_pend_d = (CW'(Din) >= LIMIT);
                    iter_d     = IW'(N);
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                sr_d   = {sr_adj[SW-2:0], 1'b0};
                iter_d = iter_q - 1'b1;
                if (iter_q == IW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : digits_fmt;
                ovf_d   = ovf_pend_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            sr_q       <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sr_q       <= sr_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign bcd      = bcd_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_averaged_bcd_converter.sv
// Directed bench for averaged_bcd_converter: a 5-digit and a 4-digit instance
// share clock, reset, EN and Din (UPDATE_PERIOD=32) and are checked cycle-exactly.
// Expected BCD words are hand-computed constants, chosen per build of the blank option.

module tb_averaged_bcd_converter;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        EN;
    logic [15:0] Din;
    logic [19:0] bcd5;
    logic        valid5, busy5, ovf5;
    logic [15:0] bcd4;
    logic        valid4, busy4, ovf4;

    int tests = 0;
    int fails = 0;

    averaged_bcd_converter #(.N(16), .DIGITS(5), .UPDATE_PERIOD(32)) dut5 (
        .clk      (clk),
        .reset    (reset),
        .EN       (EN),
        .Din      (Din),
        .bcd      (bcd5),
        .valid    (valid5),
        .busy     (busy5),
        .overflow (ovf5)
    );

    averaged_bcd_converter #(.N(16), .DIGITS(4), .UPDATE_PERIOD(32)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .EN       (EN),
        .Din      (Din),
        .bcd      (bcd4),
        .valid    (valid4),
        .busy     (busy4),
        .overflow (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits pre cycles (no valid allowed), expects the capture tick on the next
    // edge, then follows the 17-cycle conversion and checks both results.
    task automatic run(input int pre, input logic [15:0] din, input logic [15:0] late_din,
                       input bit en_drop, input logic [19:0] e5, input logic [15:0] e4,
                       input logic e4_ovf, input string tag);
        int vcnt;
        int bhi;
        int vearly;
        Din  = din;
        vcnt = 0;
        for (int i = 0; i < pre; i++) begin
            step();
            vcnt += int'(valid5 | valid4);
        end
        check({tag, "_pre_busy"}, 64'(busy5), 64'(0));
        check({tag, "_pre_valid"}, 64'(vcnt), 64'(0));
        step();
        check({tag, "_capture_busy"}, 64'(busy5), 64'(1));
        bhi    = int'(busy5);
        vearly = 0;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 5) Din = late_din;
            if (en_drop && i == 2) EN = 1'b0;
            if (i < 17) begin
                bhi    += int'(busy5);
                vearly += int'(valid5 | valid4);
            end
        end
        check({tag, "_valid5"}, 64'(valid5), 64'(1));
        check({tag, "_valid4"}, 64'(valid4), 64'(1));
        check({tag, "_busy_done"}, 64'(busy5), 64'(0));
        check({tag, "_bcd5"}, 64'(bcd5), 64'(e5));
        check({tag, "_ovf5"}, 64'(ovf5), 64'(0));
        check({tag, "_bcd4"}, 64'(bcd4), 64'(e4));
        check({tag, "_ovf4"}, 64'(ovf4), 64'(e4_ovf));
        check({tag, "_busy_cycles"}, 64'(bhi), 64'(17));
        check({tag, "_valid_early"}, 64'(vearly), 64'(0));
        step();
        check({tag, "_valid_pulse"}, 64'(valid5), 64'(0));
        check({tag, "_bcd5_hold"}, 64'(bcd5), 64'(e5));
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        EN    = 1'b0;
        Din   = 16'd0;
        repeat (3) step();
        check("reset_bcd5", 64'(bcd5), 64'(0));
        check("reset_bcd4", 64'(bcd4), 64'(0));
        check("reset_flags", 64'({valid5, busy5, ovf5, valid4, busy4, ovf4}), 64'(0));

        reset = 1'b0;
        Din   = 16'd1234;
        bad   = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if ({bcd5, valid5, busy5, ovf5, bcd4, valid4, busy4, ovf4} !== '0) bad++;
        end
        check("idle_en0", 64'(bad), 64'(0));

        // Timer sits at 0: tick on the 32nd enabled edge.
        EN = 1'b1;
        run(31, 16'd1234, 16'd1234, 1'b0, BLANK ? 20'hF1234 : 20'h01234, 16'h1234, 1'b0, "d1234");
        run(13, 16'd65535, 16'd65535, 1'b0, 20'h65535, 16'h9999, 1'b1, "d65535");
        run(13, 16'd9999, 16'd9999, 1'b0, BLANK ? 20'hF9999 : 20'h09999, 16'h9999, 1'b0, "d9999");
        run(13, 16'd7, 16'd7, 1'b0, BLANK ? 20'hFFFF7 : 20'h00007,
            BLANK ? 16'hFFF7 : 16'h0007, 1'b0, "d7");
        run(13, 16'd0, 16'd0, 1'b0, BLANK ? 20'hFFFF0 : 20'h00000,
            BLANK ? 16'hFFF0 : 16'h0000, 1'b0, "d0");
        run(13, 16'd500, 16'd42, 1'b0, BLANK ? 20'hFF500 : 20'h00500,
            BLANK ? 16'hF500 : 16'h0500, 1'b0, "d500_late42");

        // Reset on E0+8 aborts the conversion.
        Din = 16'd999;
        repeat (13) step();
        step();
        check("abort_capture_busy", 64'(busy5), 64'(1));
        repeat (7) step();
        reset = 1'b1;
        step();
        check("abort_busy", 64'({busy5, busy4}), 64'(0));
        check("abort_valid", 64'({valid5, valid4}), 64'(0));
        check("abort_bcd5", 64'(bcd5), 64'(0));
        check("abort_bcd4", 64'(bcd4), 64'(0));
        check("abort_ovf", 64'({ovf5, ovf4}), 64'(0));
        reset = 1'b0;
        run(31, 16'd321, 16'd321, 1'b0, BLANK ? 20'hFF321 : 20'h00321,
            BLANK ? 16'hF321 : 16'h0321, 1'b0, "post_reset");

        // EN low for 10 cycles with timer at 20 delays the capture by 10.
        repeat (2) step();
        EN  = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            bad += int'(valid5 | busy5);
        end
        check("en_gap_quiet", 64'(bad), 64'(0));
        EN = 1'b1;
        run(11, 16'd88, 16'd88, 1'b0, BLANK ? 20'hFFF88 : 20'h00088,
            BLANK ? 16'hFF88 : 16'h0088, 1'b0, "en_gap");

        // EN low on the tick cycle: counter holds at 31, no capture.
        repeat (13) step();
        EN  = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            bad += int'(valid5 | busy5);
        end
        check("en_tick_hold", 64'(bad), 64'(0));
        EN = 1'b1;
        // EN also drops mid-conversion; the conversion still completes.
        run(0, 16'd4321, 16'd4321, 1'b1, BLANK ? 20'hF4321 : 20'h04321, 16'h4321, 1'b0, "en_tick");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
